rns_binary_to_residue: RTL and testbench
========================================

// Module: rns_binary_to_residue
// PURPOSE
//  Forward RNS converter: turns a binary operand X into residues over the
//  moduli set {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}. Output residues feed the
//  reverse converter (S1..S4 / p1..p3 chain).
//  Sequential bit-serial Horner engine, MSB first, one bit per clock.
//  valid/ready handshake on both sides.
// PARAMETERS
//  N       8   base exponent; moduli 255, 256, 257, 511 at default; legal 4..16
//  DATA_W  32  operand width; legal N+1..64
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         X is valid
//  in_ready   out  1         converter can accept X
//  x          in   DATA_W    unsigned binary operand
//  out_valid  out  1         residues valid
//  out_ready  in   1         consumer accepts residues
//  r1         out  N         X mod (2^N-1), range 0..2^N-2
//  r2         out  N         X mod 2^N
//  r3         out  N+1       X mod (2^N+1), range 0..2^N
//  r4         out  N+1       X mod (2^(N+1)-1), range 0..2^(N+1)-2
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0; r1..r4=0; shift reg and bit counter=0.
//    in_ready=1 once reset is released. Reset mid-conversion aborts it; no output.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE:  on in_valid&&in_ready, load x into shift reg, clear 4 accumulators,
//           load counter=DATA_W-1, go to SHIFT.
//    SHIFT: each cycle take b=MSB of shift reg, shift left. For each modulus M:
//           acc <= (2*acc+b >= M) ? 2*acc+b-M : 2*acc+b.
//           Counter reaches 0 -> go to DONE.
//    DONE:  out_valid=1; r1..r4 registered and held stable until out_ready.
//  - Latency: out_valid rises exactly DATA_W clocks after the accepting edge
//    (32 at default).
//  - in_ready = (state==IDLE) || (state==DONE && out_ready).
//    Allows back-to-back operation: a new X accepted in the same cycle as the
//    result handshake goes straight to SHIFT. Throughput is one result per
//    DATA_W+1 clocks sustained.
//  - out_ready low in DONE: hold state and outputs; x/in_valid ignored.
//    in_valid while in SHIFT is ignored, since in_ready=0.
//  - Arithmetic: accumulators N+2 bits wide internally, so 2*acc+b never
//    overflows. One conditional subtract suffices because acc<M.
//    The value M itself is never produced; 0 is the single zero form for 2^N-1.
//  - 2^N channel uses the same step with M=2^N, so it is width-exact.
//    It is not a special-cased slice of x.
// STRUCTURE
//  - Package rns_pkg: FSM state enum (IDLE, SHIFT, DONE), and constant functions
//    mod_m1(N)=2^N-1, mod_m2(N)=2^N, mod_m3(N)=2^N+1, mod_m4(N)=2^(N+1)-1.
//    These are shared with the reverse converter.
//  - Sub-module rns_mod_step #(W,M): combinational one-bit Horner step
//    (acc,b)->acc'. Instantiated 4x; the FSM, counter and handshake stay in top.
// TESTING  (N=8, DATA_W=32)
//  - x=0 -> r1=0 r2=0 r3=0 r4=0; out_valid exactly 32 clks after accept.
//  - x=1000 -> r1=235 r2=232 r3=229 r4=489.
//  - x=32'hFFFFFFFF -> r1=0 r2=255 r3=0 r4=31 (checks that a value equal to
//    the modulus folds to 0).
//  - x=255 -> 0,255,255,255; x=511 -> 1,255,254,0.
//  - Backpressure, x=1000: out_ready low for 5 clks in DONE -> outputs stable
//    and in_ready=0. Then out_ready=1 with in_valid=1, x=511 -> new job accepted
//    in the same cycle; next result 1,255,254,0 arrives 32 clks later.
//  - Assert rst_n low at SHIFT cycle 10 -> out_valid=0 and r1..r4=0 immediately.
//    After release, x=1000 converts correctly with no stale result.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared RNS definitions: converter FSM states and the moduli-set constant functions
// {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}, also used by the reverse converter.
package rns_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rns_state_t;

    function automatic int mod_m1(input int n);
        return (1 << n) - 1;
    endfunction

    function automatic int mod_m2(input int n);
        return 1 << n;
    endfunction

    function automatic int mod_m3(input int n);
        return (1 << n) + 1;
    endfunction

    function automatic int mod_m4(input int n);
        return (1 << (n + 1)) - 1;
    endfunction

endpackage

// File: rtl/rns_mod_step.sv
// One combinational Horner step for modulus M: acc' = (2*acc + b) mod M, given acc < M.
module rns_mod_step #(
    parameter int W = 10,
    parameter int M = 255
) (
    input  logic [W-1:0] acc,
    input  logic         b,
    output logic [W-1:0] acc_next
);

    localparam logic [W:0] MV = (W+1)'(M);

    logic [W:0] t;

    // 2*acc+b < 2M, so a single conditional subtract lands in 0..M-1
    assign t        = {acc, b};
    assign acc_next = W'((t >= MV) ? (t - MV) : t);

endmodule

// File: rtl/rns_binary_to_residue.sv
// Bit-serial forward RNS converter: MSB-first Horner evaluation of x over four moduli,
// valid/ready on both sides, one result per DATA_W+1 clocks when streaming.
module rns_binary_to_residue
    import rns_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      r1,
    output logic [N-1:0]      r2,
    output logic [N:0]        r3,
    output logic [N:0]        r4
);

    // state | meaning
    // IDLE  | waiting for an operand, in_ready=1
    // SHIFT | consuming one operand bit per clock, counter counts down to 0
    // DONE  | residues valid, held until out_ready

    localparam int            AW       = N + 2;
    localparam int            CW       = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W - 1);

    rns_state_t        state, state_nxt;
    logic [DATA_W-1:0] sreg;
    logic [CW-1:0]     cnt;
    logic              load;
    logic              bit_in;
    logic [AW-1:0]     acc1, acc2, acc3, acc4;
    logic [AW-1:0]     nxt1, nxt2, nxt3, nxt4;

    assign bit_in = sreg[DATA_W-1];

    rns_mod_step #(.W(AW), .M(mod_m1(N))) u_step1 (.acc(acc1), .b(bit_in), .acc_next(nxt1));
    rns_mod_step #(.W(AW), .M(mod_m2(N))) u_step2 (.acc(acc2), .b(bit_in), .acc_next(nxt2));
    rns_mod_step #(.W(AW), .M(mod_m3(N))) u_step3 (.acc(acc3), .b(bit_in), .acc_next(nxt3));
    rns_mod_step #(.W(AW), .M(mod_m4(N))) u_step4 (.acc(acc4), .b(bit_in), .acc_next(nxt4));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // result handshake and next accept may share one edge
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
            acc1 <= '0;
            acc2 <= '0;
            acc3 <= '0;
            acc4 <= '0;
            r1   <= '0;
            r2   <= '0;
            r3   <= '0;
            r4   <= '0;
        end else if (load) begin
            sreg <= x;
            cnt  <= CNT_LOAD;
            acc1 <= '0;
            acc2 <= '0;
            acc3 <= '0;
            acc4 <= '0;
        end else if (state == SHIFT) begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
            cnt  <= cnt - 1'b1;
            acc1 <= nxt1;
            acc2 <= nxt2;
            acc3 <= nxt3;
            acc4 <= nxt4;
            if (cnt == '0) begin
                r1 <= N'(nxt1);
                r2 <= N'(nxt2);
                r3 <= (N+1)'(nxt3);
                r4 <= (N+1)'(nxt4);
            end
        end
    end

endmodule

// File: tb/tb_rns_binary_to_residue.sv
// Bench for rns_binary_to_residue at N=8, DATA_W=32: vector table plus scoreboard,
// with backpressure, back-to-back accept and mid-conversion reset sequences.
module tb_rns_binary_to_residue;

    localparam int N      = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      r1, r2;
    logic [N:0]        r3, r4;

    typedef struct {
        int unsigned r1;
        int unsigned r2;
        int unsigned r3;
        int unsigned r4;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rns_binary_to_residue #(.N(N), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3),
        .r4        (r4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        longint unsigned lv;
        lv   = 64'(v);
        e.r1 = int'(lv % 255);
        e.r2 = int'(lv % 256);
        e.r3 = int'(lv % 257);
        e.r4 = int'(lv % 511);
        return e;
    endfunction

    // scoreboard: a result transfers on the edge following a negedge with valid&ready
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_r1", longint'(r1), longint'(e.r1));
                chk("sb_r2", longint'(r2), longint'(e.r2));
                chk("sb_r3", longint'(r3), longint'(e.r3));
                chk("sb_r4", longint'(r4), longint'(e.r4));
            end
        end
    end

    task automatic run_job(input logic [31:0] xv, input exp_t e, input bit chatter);
        int cyc;
        @(negedge clk);
        x        = xv;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_ready", longint'(in_ready), 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (chatter) x = 32'hDEADBEEF;
        else in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == DATA_W - 2) in_valid = 1'b0;
        end
        chk("latency", longint'(cyc), longint'(DATA_W));
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        chk("idle_after_handshake", longint'(out_valid), 0);
    endtask

    initial begin
        vec_t vecs[8];
        exp_t e;
        int   cyc;
        bit   seen;

        vecs[0] = '{32'd0,          '{0, 0, 0, 0}};
        vecs[1] = '{32'd1000,       '{235, 232, 229, 489}};
        vecs[2] = '{32'hFFFFFFFF,   '{0, 255, 0, 31}};
        vecs[3] = '{32'd255,        '{0, 255, 255, 255}};
        vecs[4] = '{32'd511,        '{1, 255, 254, 0}};
        for (int i = 5; i < 8; i++) begin
            vecs[i].x = $urandom;
            vecs[i].e = model(vecs[i].x);
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_r1", longint'(r1), 0);
        chk("rst_r4", longint'(r4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].x, vecs[i].e, i == 7);
            drain();
        end

        // backpressure in DONE, then handshake and new accept on the same edge
        out_ready = 1'b0;
        run_job(32'd1000, '{235, 232, 229, 489}, 1'b0);
        in_valid = 1'b1;
        x        = 32'd511;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_r1", longint'(r1), 235);
            chk("bp_r2", longint'(r2), 232);
            chk("bp_r3", longint'(r3), 229);
            chk("bp_r4", longint'(r4), 489);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", longint'(in_ready), 1);
        exp_q.push_back('{1, 255, 254, 0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_out_valid_low", longint'(out_valid), 0);
        chk("b2b_in_ready_low", longint'(in_ready), 0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b_latency", longint'(cyc), longint'(DATA_W));
        drain();

        // reset during SHIFT aborts the job with no output
        @(negedge clk);
        x        = 32'd1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("abort_in_shift", longint'(in_ready), 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_r1", longint'(r1), 0);
        chk("abort_r2", longint'(r2), 0);
        chk("abort_r3", longint'(r3), 0);
        chk("abort_r4", longint'(r4), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_stale_result", longint'(seen), 0);
        e = model(32'd1000);
        run_job(32'd1000, e, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        chk("sb_empty", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
